// File: rtl/dbg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbg_scan_pkg
// Description : Shared constants and FSM state encoding for the virtual-JTAG
//               debug scan master.
// Revision    : 1.0 - initial release
// ============================================================================
package dbg_scan_pkg;

  localparam int DBG_DR_W = 38;
  localparam int DBG_IR_W = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UIR  = 3'd1,
    CDR  = 3'd2,
    SDR  = 3'd3,
    E1DR = 3'd4,
    RSP  = 3'd5
  } dbg_state_e;

  // States during which TCK runs; IDLE and RSP keep TCK parked low.
  function automatic logic is_scan_state(input dbg_state_e s);
    return (s == UIR) || (s == CDR) || (s == SDR) || (s == E1DR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_scan_tck_gen.sv
`default_nettype none
// ============================================================================
// Module      : dbg_scan_tck_gen
// Description : TCK divider. While enabled, TCK starts low and toggles every
//               TCK_DIV clk cycles; single-cycle strobes flag the clk edge on
//               which TCK rises or falls. Disabled -> counter cleared, TCK low.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_scan_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] c_last = 8'(TCK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       tck_q, tck_d;
  logic       w_last;

  assign w_last = (cnt_q == c_last);

  // Next divider count and TCK level; an idle divider always restarts a period.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    tck_d = tck_q;
    if (!en_i) begin
      cnt_d = 8'd0;
      tck_d = 1'b0;
    end else if (w_last) begin
      cnt_d = 8'd0;
      tck_d = ~tck_q;
    end
  end

  // Divider and TCK registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o  = tck_q;
  assign rise_o = en_i && w_last && !tck_q;
  assign fall_o = en_i && w_last &&  tck_q;

endmodule
`default_nettype wire

// File: rtl/jtag_dbg_scan_master.sv
`default_nettype none
// ============================================================================
// Module      : jtag_dbg_scan_master
// Description : Virtual-JTAG debug scan master. Accepts an IR/DR command,
//               walks UIR -> CDR -> SDR(DR_W periods) -> E1DR, shifting
//               cmd_dr out on TDI LSB first and capturing TDO, then presents
//               the captured word on the response handshake.
//               Optional macro DBG_SCAN_IR_SKIP_EN: skip UIR when the new IR
//               equals the IR already loaded (never on the first command
//               after reset).
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_dbg_scan_master
  import dbg_scan_pkg::*;
#(
  parameter int TCK_DIV = 4,
  parameter int DR_W    = DBG_DR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DBG_IR_W-1:0] cmd_ir,
  input  logic [DR_W-1:0]     cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_W-1:0]     rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [DBG_IR_W-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_e1dr,
  output logic                vji_rti
);

  localparam int CNT_W = $clog2(DR_W + 1);
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DR_W - 1);

  dbg_state_e          state_q, state_d;
  logic [DR_W-1:0]     sh_q;
  logic [DR_W-1:0]     rsp_dr_q;
  logic                tdi_q;
  logic [DBG_IR_W-1:0] ir_q;
  logic [CNT_W-1:0]    bit_cnt_q;

  logic w_tck_en, w_rise, w_fall;
  logic w_accept, w_skip_uir, w_last_bit;

  assign w_accept   = cmd_valid && (state_q == IDLE);
  assign w_last_bit = (bit_cnt_q == c_last_bit);
  assign w_tck_en   = is_scan_state(state_q);

  dbg_scan_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk    (clk),
    .reset  (reset),
    .en_i   (w_tck_en),
    .tck_o  (vji_tck),
    .rise_o (w_rise),
    .fall_o (w_fall)
  );

`ifdef DBG_SCAN_IR_SKIP_EN
  logic ir_seen_q;

  // Remembers that vji_ir_in holds a genuinely loaded IR (not the reset value).
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_seen_q <= 1'b0;
    end else if (w_accept) begin
      ir_seen_q <= 1'b1;
    end
  end

  assign w_skip_uir = ir_seen_q && (cmd_ir == ir_q);
`else
  assign w_skip_uir = 1'b0;
`endif

  // Next-state logic; every scan state advances on the TCK falling strobe,
  // which is the clk edge that closes a whole TCK period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = w_skip_uir ? CDR : UIR;
      UIR:     if (w_fall) state_d = CDR;
      CDR:     if (w_fall) state_d = SDR;
      SDR:     if (w_fall && w_last_bit) state_d = E1DR;
      E1DR:    if (w_fall) state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any scan in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan datapath: command latch, TDI shifter on falling TCK, TDO capture on
  // rising TCK. TDI for period k is launched by the fall that opens period k.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q      <= '0;
      rsp_dr_q  <= '0;
      tdi_q     <= 1'b0;
      ir_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      if (w_accept) begin
        sh_q <= cmd_dr;
        ir_q <= cmd_ir;
      end
      if ((state_q == CDR) && w_fall) begin
        tdi_q     <= sh_q[0];
        sh_q      <= sh_q >> 1;
        bit_cnt_q <= '0;
      end
      if ((state_q == SDR) && w_fall) begin
        if (w_last_bit) begin
          tdi_q <= 1'b0;
        end else begin
          tdi_q     <= sh_q[0];
          sh_q      <= sh_q >> 1;
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end
      if ((state_q == SDR) && w_rise) begin
        rsp_dr_q <= {vji_tdo, rsp_dr_q[DR_W-1:1]};
      end
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_dr    = rsp_dr_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_q;
  assign vji_uir   = (state_q == UIR);
  assign vji_cdr   = (state_q == CDR);
  assign vji_sdr   = (state_q == SDR);
  assign vji_e1dr  = (state_q == E1DR);
  assign vji_rti   = (state_q == IDLE) || (state_q == RSP);

endmodule
`default_nettype wire

// File: tb/tb_jtag_dbg_scan_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_jtag_dbg_scan_master
// Description : Self-checking bench for jtag_dbg_scan_master (TCK_DIV=2,
//               DR_W=38). Stimulus pushes expected responses into a queue;
//               a negedge monitor pops and compares on each rsp handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_dbg_scan_master;

  localparam int TCK_DIV = 2;
  localparam int DR_W    = 38;
`ifdef DBG_SCAN_IR_SKIP_EN
  localparam int UIR_EXP = 1;
`else
  localparam int UIR_EXP = 2;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_ir;
  logic [DR_W-1:0] cmd_dr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DR_W-1:0] rsp_dr;
  logic            vji_tck, vji_tdi, vji_tdo;
  logic [1:0]      vji_ir_in;
  logic            vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_rti;
  logic [1:0]      tdo_mode;   // 0: loop TDI, 1: tie high, 2: tie low

  assign vji_tdo = (tdo_mode == 2'd0) ? vji_tdi : (tdo_mode == 2'd1);

  always #5 clk = ~clk;

  jtag_dbg_scan_master #(
    .TCK_DIV (TCK_DIV),
    .DR_W    (DR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir    (cmd_ir),
    .cmd_dr    (cmd_dr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dr    (rsp_dr),
    .vji_tck   (vji_tck),
    .vji_tdi   (vji_tdi),
    .vji_tdo   (vji_tdo),
    .vji_ir_in (vji_ir_in),
    .vji_uir   (vji_uir),
    .vji_cdr   (vji_cdr),
    .vji_sdr   (vji_sdr),
    .vji_e1dr  (vji_e1dr),
    .vji_rti   (vji_rti)
  );

  int checks = 0;
  int errors = 0;
  logic [DR_W-1:0] exp_q[$];

  int cyc = 0, accepts = 0, last_acc_cyc = 0, lat = 0;
  int rsp_rises = 0, uir_rises = 0;
  int sdr_rises_live = 0, sdr_cycles_live = 0, sdr_periods = 0, sdr_cycles = 0;
  logic prev_tck = 1'b0, prev_tdi = 1'b0, prev_sdr = 1'b0;
  logic prev_uir = 1'b0, prev_rspv = 1'b0;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Monitor: protocol assertions, event counters and scoreboard compare.
  initial begin
    logic [DR_W-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        checks++;
        a_onehot: assert ($onehot0({vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_rti})) else begin
          errors++;
          $display("FAIL strobe_onehot0: got %b", {vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_rti});
        end
        if (vji_tdi !== prev_tdi) begin
          checks++;
          a_tdi: assert (vji_tck == 1'b0) else begin
            errors++;
            $display("FAIL tdi_change_tck_low: tck %b when tdi changed", vji_tck);
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        accepts++;
        last_acc_cyc = cyc;
      end
      if (rsp_valid && !prev_rspv) begin
        rsp_rises++;
        lat = cyc - last_acc_cyc;
      end
      if (vji_uir && !prev_uir) uir_rises++;
      if (vji_sdr && !prev_sdr) begin
        sdr_rises_live  = 0;
        sdr_cycles_live = 0;
      end
      if (vji_sdr) begin
        sdr_cycles_live++;
        if (vji_tck && !prev_tck) sdr_rises_live++;
      end
      if (!vji_sdr && prev_sdr) begin
        sdr_periods = sdr_rises_live;
        sdr_cycles  = sdr_cycles_live;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got %0h expected none", rsp_dr);
        end else begin
          e = exp_q.pop_front();
          check("rsp_dr", 64'(rsp_dr), 64'(e));
        end
      end
      prev_tck  = vji_tck;
      prev_tdi  = vji_tdi;
      prev_sdr  = vji_sdr;
      prev_uir  = vji_uir;
      prev_rspv = rsp_valid;
    end
  end

  // Hold cmd_valid (caller set it) until accepted; returns #1 after the accept edge.
  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: got no accept expected accept", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ir, input logic [DR_W-1:0] dr);
    cmd_ir    = ir;
    cmd_dr    = dr;
    cmd_valid = 1'b1;
    wait_accept("accept");
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_done(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: got no response expected response", name);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int u0, a0, r0;
    bit ok;
    logic [DR_W-1:0] dr_a, dr_b;
    dr_a      = 38'h00_1234_5678;
    dr_b      = 38'h3F_0F0F_0F0F;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_ir    = 2'b00;
    cmd_dr    = '0;
    rsp_ready = 1'b1;
    tdo_mode  = 2'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state",
          64'({cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_rti}),
          64'(11'b1_0_0_0_00_0000_1));
    check("reset_rsp_dr", 64'(rsp_dr), 64'd0);

    // Loopback scan: response equals the shifted-out word; latency 2*2*41+1.
    @(posedge clk); #1;
    exp_q.push_back(38'h15_5555_5555);
    send(2'b01, 38'h15_5555_5555);
    check("ir_in_after_accept", 64'(vji_ir_in), 64'd1);
    wait_rsp_done("rsp_loopback");
    check("latency", 64'(lat), 64'd165);

    // TDO tied high: all ones captured, SDR exactly 38 TCK periods.
    tdo_mode = 2'd1;
    exp_q.push_back(38'h3F_FFFF_FFFF);
    send(2'b11, 38'h0A_AAAA_AAAA);
    wait_rsp_done("rsp_tdo_high");
    check("sdr_tck_periods", 64'(sdr_periods), 64'd38);
    check("sdr_clk_cycles", 64'(sdr_cycles), 64'd152);

    // TDO tied low: all zeros captured regardless of TDI.
    tdo_mode = 2'd2;
    exp_q.push_back(38'h00_0000_0000);
    send(2'b11, 38'h3F_FFFF_FFFF);
    wait_rsp_done("rsp_tdo_low");

    // Back-to-back with response back-pressure, both IR = 2'b10.
    tdo_mode  = 2'd0;
    rsp_ready = 1'b0;
    u0 = uir_rises;
    a0 = accepts;
    exp_q.push_back(dr_a);
    exp_q.push_back(dr_b);
    cmd_ir    = 2'b10;
    cmd_dr    = dr_a;
    cmd_valid = 1'b1;
    wait_accept("accept_a");
    cmd_dr = dr_b;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    check("rsp_a_arrives", 64'(ok), 64'd1);
    for (int i = 0; i < 20; i++) begin
      check("hold_under_backpressure", 64'({rsp_valid, cmd_ready, rsp_dr}), 64'({1'b1, 1'b0, dr_a}));
      @(negedge clk);
    end
    check("no_accept_while_busy", 64'(accepts - a0), 64'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_accept("accept_b");
    cmd_valid = 1'b0;
    check("accept_b_after_rsp", 64'(accepts - a0), 64'd2);
    wait_rsp_done("rsp_b");
    check("uir_pulses_same_ir", 64'(uir_rises - u0), 64'(UIR_EXP));
    check("ir_in_b", 64'(vji_ir_in), 64'd2);

    // Reset at SDR bit 17: scan discarded, no response.
    r0 = rsp_rises;
    send(2'b01, 38'h2A_AAAA_AAAA);
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(posedge clk); #1;
      if (vji_sdr && sdr_rises_live == 18) ok = 1'b1;
    end
    check("reach_sdr_bit17", 64'(ok), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_sdr_reset_state",
          64'({cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_sdr, vji_rti, vji_ir_in}),
          64'(8'b1_0_0_0_0_1_00));
    check("mid_sdr_reset_rsp_dr", 64'(rsp_dr), 64'd0);
    repeat (200) @(negedge clk);
    check("no_rsp_after_reset", 64'(rsp_rises - r0), 64'd0);

    // First command after reset uses IR 0 (equal to reset IR) and must do UIR.
    @(posedge clk); #1;
    u0 = uir_rises;
    exp_q.push_back(38'h20_0000_0001);
    send(2'b00, 38'h20_0000_0001);
    wait_rsp_done("rsp_after_reset");
    check("uir_first_after_reset", 64'(uir_rises - u0), 64'd1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
